// File: rtl/ssd_scan_driver.sv
// Time-multiplexed seven-segment scan driver with per-digit enable, decimal points,
// leading-zero blanking, PWM dimming and frame-synchronised double buffering.
module ssd_scan_driver #(
    parameter int unsigned NUM_DIGITS = 8,
    parameter int unsigned SCAN_DIV   = 18,
    parameter int unsigned DIM_BITS   = 4
) (
    input  logic                      ClkPort,
    input  logic                      Reset_n,
    input  logic [4*NUM_DIGITS-1:0]   DigitData,
    input  logic [NUM_DIGITS-1:0]     DpIn,
    input  logic [NUM_DIGITS-1:0]     DigitEn,
    input  logic                      LzSuppress,
    input  logic [DIM_BITS-1:0]       Brightness,
    input  logic                      Load,
    output logic [NUM_DIGITS-1:0]     An,
    output logic [7:0]                Cathodes,
    output logic                      FrameStart
);

    localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned DATA_W = 4 * NUM_DIGITS;
    localparam logic [SCAN_DIV-1:0] PRESC_MAX = '1;
    localparam logic [IDX_W-1:0]    IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    logic [SCAN_DIV-1:0]   presc;
    logic [IDX_W-1:0]      idx;

    logic [DATA_W-1:0]     act_data, pend_data;
    logic [NUM_DIGITS-1:0] act_dp, pend_dp;
    logic [NUM_DIGITS-1:0] act_en, pend_en;
    logic                  pend_flag;

    logic                  slot_end;
    logic                  boundary;
    logic [NUM_DIGITS-1:0] blank_lz;
    logic [NUM_DIGITS-1:0] lit;
    logic                  run_zero;
    logic [3:0]            cur_nib;
    logic                  cur_dp;
    logic                  cur_lit;
    logic [DIM_BITS-1:0]   phase;
    logic                  pwm_on;
    logic [NUM_DIGITS-1:0] an_nxt;
    logic [7:0]            cath_nxt;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0:    seg7 = 7'b0000001;
            4'h1:    seg7 = 7'b1001111;
            4'h2:    seg7 = 7'b0010010;
            4'h3:    seg7 = 7'b0000110;
            4'h4:    seg7 = 7'b1001100;
            4'h5:    seg7 = 7'b0100100;
            4'h6:    seg7 = 7'b0100000;
            4'h7:    seg7 = 7'b0001111;
            4'h8:    seg7 = 7'b0000000;
            4'h9:    seg7 = 7'b0000100;
            4'hA:    seg7 = 7'b0001000;
            4'hB:    seg7 = 7'b1100000;
            4'hC:    seg7 = 7'b0110001;
            4'hD:    seg7 = 7'b1000010;
            4'hE:    seg7 = 7'b0110000;
            default: seg7 = 7'b0111000;
        endcase
    endfunction

    // Scan timing, blanking and next-cycle output values
    always_comb begin
        slot_end = (presc == PRESC_MAX);
        boundary = slot_end && (idx == IDX_LAST);

        // Leading-zero run from the top digit down; a disabled digit reads as blank zero
        blank_lz = '0;
        run_zero = LzSuppress;
        for (int i = int'(NUM_DIGITS) - 1; i >= 1; i--) begin
            run_zero    = run_zero && (!act_en[i] || ((act_data[4*i +: 4] == 4'h0) && !act_dp[i]));
            blank_lz[i] = run_zero;
        end
        lit = act_en & ~blank_lz;

        cur_nib = 4'h0;
        cur_dp  = 1'b0;
        cur_lit = 1'b0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (IDX_W'(i) == idx) begin
                cur_nib = act_data[4*i +: 4];
                cur_dp  = act_dp[i];
                cur_lit = lit[i];
            end
        end

        phase  = presc[SCAN_DIV-1 -: DIM_BITS];
        pwm_on = (Brightness == '1) || (phase < Brightness);

        an_nxt = '1;
        if ((presc != '0) && cur_lit && pwm_on) begin
            an_nxt = ~(NUM_DIGITS'(1) << idx);
        end
        cath_nxt = {seg7(cur_nib), ~cur_dp};
    end

    // Prescaler, digit index and registered outputs
    always_ff @(posedge ClkPort or negedge Reset_n) begin
        if (!Reset_n) begin
            presc      <= '0;
            idx        <= '0;
            An         <= '1;
            Cathodes   <= 8'hFF;
            FrameStart <= 1'b0;
        end else begin
            presc <= presc + SCAN_DIV'(1);
            if (slot_end) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
            end
            An         <= an_nxt;
            Cathodes   <= cath_nxt;
            FrameStart <= boundary;
        end
    end

    // Double buffer: a Load on the boundary cycle bypasses pending straight to active
    always_ff @(posedge ClkPort or negedge Reset_n) begin
        if (!Reset_n) begin
            act_data  <= '0;
            act_dp    <= '0;
            act_en    <= '0;
            pend_data <= '0;
            pend_dp   <= '0;
            pend_en   <= '0;
            pend_flag <= 1'b0;
        end else if (boundary && Load) begin
            act_data  <= DigitData;
            act_dp    <= DpIn;
            act_en    <= DigitEn;
            pend_flag <= 1'b0;
        end else if (boundary && pend_flag) begin
            act_data  <= pend_data;
            act_dp    <= pend_dp;
            act_en    <= pend_en;
            pend_flag <= 1'b0;
        end else if (Load) begin
            pend_data <= DigitData;
            pend_dp   <= DpIn;
            pend_en   <= DigitEn;
            pend_flag <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Randomised bench for ssd_scan_driver against a cycle-count based display model,
// plus literal expectations for the scan, dimming, blanking and buffering corners.
module tb_ssd_scan_driver;

    localparam int unsigned ND = 4;
    localparam int unsigned SD = 4;
    localparam int unsigned DB = 2;
    localparam int SLOT  = 16;
    localparam int FRAME = 64;

    logic          ClkPort = 1'b0;
    logic          Reset_n;
    logic [15:0]   DigitData;
    logic [3:0]    DpIn;
    logic [3:0]    DigitEn;
    logic          LzSuppress;
    logic [1:0]    Brightness;
    logic          Load;
    logic [3:0]    An;
    logic [7:0]    Cathodes;
    logic          FrameStart;

    int n_checks = 0;
    int n_errors = 0;

    ssd_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .DIM_BITS(DB)) dut (
        .ClkPort(ClkPort), .Reset_n(Reset_n), .DigitData(DigitData), .DpIn(DpIn),
        .DigitEn(DigitEn), .LzSuppress(LzSuppress), .Brightness(Brightness), .Load(Load),
        .An(An), .Cathodes(Cathodes), .FrameStart(FrameStart)
    );

    always #5 ClkPort = ~ClkPort;

    logic [6:0] seg_tab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                 7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                 7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                                 7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: clocks since reset give slot and phase directly
    int          cyc;
    logic [15:0] m_data, p_data;
    logic [3:0]  m_dp, p_dp, m_en, p_en;
    logic        p_flag;
    logic [3:0]  e_an;
    logic [7:0]  e_cath;
    logic        e_fs;

    function automatic logic [3:0] exp_an(input int c, input logic [15:0] d, input logic [3:0] dp,
                                          input logic [3:0] en, input logic [1:0] br, input logic lz);
        int pr  = c % SLOT;
        int dg  = (c / SLOT) % ND;
        int top = 0;
        bit shown;
        for (int i = 0; i < 4; i++)
            if (en[i] && (d[4*i +: 4] != 4'h0 || dp[i])) top = i;
        shown = en[dg] && !(lz && dg > top);
        if (pr == 0 || !shown) return 4'hF;
        if (!(br == 2'd3 || (pr / 4) < int'(br))) return 4'hF;
        return ~(4'b0001 << dg);
    endfunction

    function automatic logic [7:0] exp_cath(input int c, input logic [15:0] d, input logic [3:0] dp);
        int dg = (c / SLOT) % ND;
        return {seg_tab[d[4*dg +: 4]], ~dp[dg]};
    endfunction

    always @(posedge ClkPort or negedge Reset_n) begin
        if (!Reset_n) begin
            cyc <= 0;
            m_data <= '0; m_dp <= '0; m_en <= '0;
            p_data <= '0; p_dp <= '0; p_en <= '0; p_flag <= 1'b0;
            e_an <= 4'hF; e_cath <= 8'hFF; e_fs <= 1'b0;
        end else begin
            e_an   <= exp_an(cyc, m_data, m_dp, m_en, Brightness, LzSuppress);
            e_cath <= exp_cath(cyc, m_data, m_dp);
            e_fs   <= (cyc % FRAME) == FRAME - 1;
            if ((cyc % FRAME) == FRAME - 1 && Load) begin
                m_data <= DigitData; m_dp <= DpIn; m_en <= DigitEn; p_flag <= 1'b0;
            end else if ((cyc % FRAME) == FRAME - 1 && p_flag) begin
                m_data <= p_data; m_dp <= p_dp; m_en <= p_en; p_flag <= 1'b0;
            end else if (Load) begin
                p_data <= DigitData; p_dp <= DpIn; p_en <= DigitEn; p_flag <= 1'b1;
            end
            cyc <= cyc + 1;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge ClkPort) begin
        chk("an", int'(An), int'(e_an));
        chk("cathodes", int'(Cathodes), int'(e_cath));
        chk("frame_start", int'(FrameStart), int'(e_fs));
        chk("an_onehot", int'($countones(~An) <= 1), 1);
    end

    int     lowcnt [4];
    logic [7:0] slotcath [4];
    int     fs_cnt;

    task automatic do_load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] en);
        @(negedge ClkPort);
        DigitData = d; DpIn = dp; DigitEn = en; Load = 1'b1;
        @(negedge ClkPort);
        Load = 1'b0;
    endtask

    // Wait for FrameStart, then observe the following 64 output cycles
    task automatic frame_scan;
        bit found = 0;
        for (int k = 0; k < 3 * FRAME && !found; k++) begin
            @(negedge ClkPort);
            if (FrameStart) found = 1;
        end
        chk("fs_timeout", int'(found), 1);
        for (int i = 0; i < 4; i++) lowcnt[i] = 0;
        fs_cnt = 0;
        for (int k = 1; k <= FRAME; k++) begin
            @(negedge ClkPort);
            for (int i = 0; i < 4; i++) if (!An[i]) lowcnt[i]++;
            if (FrameStart) fs_cnt++;
            if (k % SLOT == 8) slotcath[k / SLOT] = Cathodes;
        end
    endtask

    task automatic wait_phase(input int ph);
        bit hit = 0;
        for (int k = 0; k < 2 * FRAME && !hit; k++) begin
            @(negedge ClkPort);
            if (cyc % FRAME == ph) hit = 1;
        end
        chk("phase_timeout", int'(hit), 1);
    endtask

    initial begin
        int bexp [4] = '{0, 3, 7, 15};
        int rel_cnt;
        bit seen;
        Reset_n = 1'b0; DigitData = '0; DpIn = '0; DigitEn = 4'hF;
        LzSuppress = 1'b0; Brightness = 2'd3; Load = 1'b0;
        repeat (3) @(negedge ClkPort);
        chk("reset_an", int'(An), 4'hF);
        chk("reset_cath", int'(Cathodes), 8'hFF);
        Reset_n = 1'b1;

        // Digits 12AF, DP on digit 1
        do_load(16'h12AF, 4'b0010, 4'hF);
        frame_scan();
        chk("slot0_cath", int'(slotcath[0]), 8'h71);
        chk("slot1_cath", int'(slotcath[1]), 8'h10);
        chk("slot2_cath", int'(slotcath[2]), 8'h25);
        chk("slot3_cath", int'(slotcath[3]), 8'h9F);
        for (int i = 0; i < 4; i++) chk("full_bright_low", lowcnt[i], 15);
        chk("fs_per_frame", fs_cnt, 1);

        // Brightness sweep
        for (int b = 0; b < 4; b++) begin
            @(negedge ClkPort);
            Brightness = 2'(b);
            frame_scan();
            chk("bright_d0", lowcnt[0], bexp[b]);
            chk("bright_d2", lowcnt[2], bexp[b]);
        end

        // Two loads inside one frame: last wins at the next frame
        repeat (5) @(negedge ClkPort);
        do_load(16'h0000, 4'b0000, 4'hF);
        repeat (10) @(negedge ClkPort);
        do_load(16'h5555, 4'b0000, 4'hF);
        frame_scan();
        for (int i = 0; i < 4; i++) chk("last_load_wins", int'(slotcath[i]), 8'h49);

        // Leading-zero suppression
        @(negedge ClkPort);
        LzSuppress = 1'b1;
        do_load(16'h0030, 4'b0000, 4'hF);
        frame_scan();
        chk("lz30_d0", lowcnt[0], 15); chk("lz30_d1", lowcnt[1], 15);
        chk("lz30_d2", lowcnt[2], 0);  chk("lz30_d3", lowcnt[3], 0);
        do_load(16'h0000, 4'b0000, 4'hF);
        frame_scan();
        chk("lz0_d0", lowcnt[0], 15); chk("lz0_d1", lowcnt[1], 0);
        chk("lz0_cath0", int'(slotcath[0]), 8'h03);
        do_load(16'h0000, 4'b1000, 4'hF);
        frame_scan();
        for (int i = 0; i < 4; i++) chk("lz_dp_all", lowcnt[i], 15);
        do_load(16'h0030, 4'b0000, 4'b1101);
        frame_scan();
        chk("lz_dis_d1", lowcnt[1], 0); chk("lz_dis_d0", lowcnt[0], 15);

        // Load on the boundary cycle goes straight to the new frame
        @(negedge ClkPort);
        LzSuppress = 1'b0;
        wait_phase(FRAME - 1);
        DigitData = 16'h9876; DpIn = 4'b0000; DigitEn = 4'hF; Load = 1'b1;
        @(negedge ClkPort);
        Load = 1'b0;
        chk("bnd_fs", int'(FrameStart), 1);
        repeat (8) @(negedge ClkPort);
        chk("bnd_slot0", int'(Cathodes), 8'h41);
        frame_scan();
        chk("bnd_hold3", int'(slotcath[3]), 8'h09);

        // Asynchronous reset mid-scan (index 2, prescaler 9)
        wait_phase(2 * SLOT + 9);
        #2 Reset_n = 1'b0;
        #1;
        chk("async_an", int'(An), 4'hF);
        chk("async_cath", int'(Cathodes), 8'hFF);
        chk("async_fs", int'(FrameStart), 0);
        @(negedge ClkPort);
        Reset_n = 1'b1;
        @(negedge ClkPort);
        chk("post_reset_an", int'(An), 4'hF);
        rel_cnt = 1; seen = 0;
        while (!seen && rel_cnt < 3 * FRAME) begin
            @(negedge ClkPort);
            rel_cnt++;
            if (FrameStart) seen = 1;
        end
        chk("first_fs_delay", rel_cnt, FRAME);

        // Randomised traffic
        for (int k = 0; k < 3000; k++) begin
            @(negedge ClkPort);
            Load = ($urandom_range(0, 31) == 0) || ((cyc % FRAME == FRAME - 1) && $urandom_range(0, 3) == 0);
            DigitData = 16'($urandom) & (16'hFFFF >> (4 * $urandom_range(0, 3)));
            DpIn = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            DigitEn = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
            if (k % 50 == 0) begin
                Brightness = 2'($urandom);
                LzSuppress = 1'($urandom);
            end
        end
        @(negedge ClkPort);
        Load = 1'b0;
        repeat (2 * FRAME) @(negedge ClkPort);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
